exu_muldiv_iter: RTL and testbench
==================================

// Module: exu_muldiv_iter
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit that sits beside the EXU ALU and feeds the HI/LO register pair.
//  Replaces the single-cycle combinational mult/div with a radix-2 iterative datapath and a start/busy/done handshake.
//  Adds two behaviours: a pipeline flush (cancel) and an optional fast-multiply mode.
// PARAMETERS
//  XLEN      32  operand width; HI/LO are XLEN each, product is 2*XLEN
//  MUL_FAST  0   1: multiply done in one CALC cycle (combinational product); 0: iterative, XLEN cycles
// PORTS
//  clk       in   1     clock, all state updates on posedge
//  rst       in   1     synchronous, active-low reset
//  start_i   in   1     request; accepted only when busy_o==0
//  op_i      in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled on accept
//  src_a_i   in   XLEN  multiplicand / dividend; sampled on accept
//  src_b_i   in   XLEN  multiplier / divisor; sampled on accept
//  flush_i   in   1     cancel in-flight op; no result, no HI/LO write
//  busy_o    out  1     1 in CALC and FIX states
//  done_o    out  1     1-cycle pulse in DONE state
//  hi_o      out  XLEN  HI result (product high half / remainder); holds until next DONE
//  lo_o      out  XLEN  LO result (product low half / quotient); holds until next DONE
//  whi_o     out  1     HI write enable; high only in DONE, and only if result is valid
//  wlo_o     out  1     LO write enable; same rule as whi_o
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE; busy_o, done_o, whi_o, wlo_o = 0; hi_o, lo_o = 0; counter = 0.
//  States: IDLE, CALC, FIX, DONE.
//   IDLE --start_i--> CALC, or directly to DONE for divide with src_b_i==0.
//   CALC: one radix-2 step per cycle; down-counter loaded with XLEN (1 if MULT* and MUL_FAST); at 0 -> FIX.
//   FIX: sign correction, one cycle -> DONE.
//   DONE: one cycle; drives done_o and updates hi_o/lo_o.
//    If start_i is high in DONE, the new op is accepted (back-to-back) -> CALC; otherwise -> IDLE.
//  Latency: done_o asserts XLEN+2 cycles after the accepting edge (3 for MUL_FAST multiply, 1 for divide-by-zero).
//  start_i while busy_o==1 is ignored; there is no queueing.
//  Signed ops (MULT, DIV): operands are converted to magnitudes on accept; results are negated in FIX:
//   product and quotient are negated if the operand signs differ;
//   remainder takes the sign of the dividend.
//  Unsigned ops: FIX passes results through unchanged.
//  Divider: restoring; XLEN+1-bit partial remainder, one quotient bit per cycle, MSB first.
//  Multiplier: shift-add into a 2*XLEN accumulator, one multiplier bit per cycle, LSB first.
//  Overflow: DIV of most-negative by -1 gives lo = most-negative, hi = 0; whi_o = wlo_o = 1.
//  Divide-by-zero: lo_o = all ones, hi_o = dividend; done_o = 1 but whi_o = wlo_o = 0 (HI/LO are not updated).
//  flush_i: any state -> IDLE at the next edge; no done_o; hi_o/lo_o keep their previous values.
//   flush_i wins over a simultaneous start_i.
//  Reset mid-operation: same as the reset values above; the operation is discarded.
// TESTING (XLEN=32)
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at accept+34; hi=0xFFFFFFFE, lo=0x00000001, whi=wlo=1.
//  MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; with MUL_FAST=1 same values, done at accept+3.
//  DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   DIVU 7/2 -> lo=3, hi=1.
//   DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  DIVU 0x1234/0 -> done at accept+1; lo=0xFFFFFFFF, hi=0x1234, whi=wlo=0.
//  Back-to-back: start_i held through DONE -> second op accepted in the DONE cycle; exactly one done_o pulse per op.
//   start_i while busy -> ignored.
//  flush_i at accept+10 -> busy_o=0 next cycle, no done_o, hi_o/lo_o unchanged.
//   rst=0 at accept+5 -> all outputs 0.

Source files
------------

// File: rtl/exu_muldiv_iter.sv
// Iterative radix-2 multiply/divide unit feeding the HI/LO pair.
// Start/busy/done handshake, flush cancel, optional single-step multiply.
module exu_muldiv_iter #(
  parameter int XLEN     = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            whi_o,
  output logic            wlo_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic              r_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_valid;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic              w_accept;
  logic              w_div0;
  logic              w_sgn;
  logic              w_last;
  logic              w_busy;
  logic              w_done;
  logic              w_wr;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_add;
  logic [2*XLEN-1:0] w_mstep;
  logic [2*XLEN-1:0] w_fprod;

  logic [XLEN:0]     w_sh;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_hi;
  logic [XLEN-1:0]   w_fix_lo;

  assign w_accept = start_i & ~flush_i &
                    ((r_state == S_IDLE) |
                     (r_state == S_DONE));
  assign w_div0   = op_i[1] & (src_b_i == '0);
  assign w_sgn    = ~op_i[0];
  assign w_last   = (r_cnt == CW'(1));

  assign w_mag_a = (w_sgn & src_a_i[XLEN-1]) ?
                   -src_a_i : src_a_i;
  assign w_mag_b = (w_sgn & src_b_i[XLEN-1]) ?
                   -src_b_i : src_b_i;

  // Shift-add: multiplier sits in acc low half, LSB first
  assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                   {1'b0, r_a};
  assign w_add   = r_acc[0] ? w_sum :
                   {1'b0, r_acc[2*XLEN-1:XLEN]};
  assign w_mstep = {w_add, r_acc[XLEN-1:1]};
  assign w_fprod = {{XLEN{1'b0}}, r_a} *
                   {{XLEN{1'b0}}, r_b};

  // Restoring divide: dividend shifts out of acc low half
  assign w_sh   = {r_rem, r_acc[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_b};
  assign w_qbit = ~w_diff[XLEN];

  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_neg_q ? -r_acc[XLEN-1:0] :
                    r_acc[XLEN-1:0];
  assign w_rem    = r_neg_r ? -r_rem : r_rem;
  assign w_fix_hi = r_div ? w_rem :
                    w_prod[2*XLEN-1:XLEN];
  assign w_fix_lo = r_div ? w_quo :
                    w_prod[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_wr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_div0 ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_wr   = r_valid;
        if (w_accept) begin
          w_next = w_div0 ? S_DONE : S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_valid <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_accept) begin
      r_a     <= w_mag_a;
      r_b     <= w_mag_b;
      r_rem   <= '0;
      r_div   <= op_i[1];
      r_neg_q <= w_sgn &
                 (src_a_i[XLEN-1] ^ src_b_i[XLEN-1]);
      r_neg_r <= w_sgn & src_a_i[XLEN-1];
      r_valid <= ~w_div0;
      r_acc   <= {{XLEN{1'b0}},
                  op_i[1] ? w_mag_a : w_mag_b};
      if (!op_i[1] && MUL_FAST) begin
        r_cnt <= CW'(1);
      end else begin
        r_cnt <= CW'(XLEN);
      end
      if (w_div0) begin
        r_hi <= src_a_i;
        r_lo <= '1;
      end
    end else if (!flush_i && r_state == S_CALC) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_div) begin
        r_rem <= w_qbit ? w_diff[XLEN-1:0] :
                 w_sh[XLEN-1:0];
        r_acc <= {r_acc[2*XLEN-1:XLEN],
                  r_acc[XLEN-2:0], w_qbit};
      end else begin
        r_acc <= MUL_FAST ? w_fprod : w_mstep;
      end
    end else if (!flush_i && r_state == S_FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end
  end

  assign busy_o = w_busy;
  assign done_o = w_done;
  assign whi_o  = w_wr;
  assign wlo_o  = w_wr;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_exu_muldiv_iter.sv
// Self-checking bench for exu_muldiv_iter (XLEN=32).
// Iterative and fast-multiply instances, vectors plus random ops.
module tb_exu_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        f_start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        s_busy, s_done, s_whi, s_wlo;
  logic [31:0] s_hi, s_lo;
  logic        f_busy, f_done, f_whi, f_wlo;
  logic [31:0] f_hi, f_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exu_muldiv_iter #(.XLEN(32), .MUL_FAST(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op),
    .src_a_i(a), .src_b_i(b), .flush_i(flush),
    .busy_o(s_busy), .done_o(s_done), .hi_o(s_hi),
    .lo_o(s_lo), .whi_o(s_whi), .wlo_o(s_wlo)
  );

  exu_muldiv_iter #(.XLEN(32), .MUL_FAST(1'b1)) u_fast (
    .clk(clk), .rst(rst), .start_i(f_start), .op_i(op),
    .src_a_i(a), .src_b_i(b), .flush_i(flush),
    .busy_o(f_busy), .done_o(f_done), .hi_o(f_hi),
    .lo_o(f_lo), .whi_o(f_whi), .wlo_o(f_wlo)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input string what,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s act=%0h exp=%0h",
               nm, what, act, exp);
    end
  endtask

  function automatic void ref_model(
    input logic [1:0] rop, input logic [31:0] ra,
    input logic [31:0] rb, output logic [31:0] hi,
    output logic [31:0] lo, output logic wr,
    output int lat);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ua = {32'd0, ra};
    ub = {32'd0, rb};
    wr = 1'b1;
    lat = 34;
    hi = '0;
    lo = '0;
    case (rop)
      2'b00: begin
        p = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        up = ua * ub;
        hi = up[63:32];
        lo = up[31:0];
      end
      default: begin
        if (rb == 0) begin
          lo = '1;
          hi = ra;
          wr = 1'b0;
          lat = 1;
        end else if (rop == 2'b10 &&
                     ra == 32'h80000000 &&
                     rb == 32'hFFFFFFFF) begin
          lo = ra;
          hi = '0;
        end else if (rop == 2'b10) begin
          p = sa / sb;
          lo = p[31:0];
          p = sa % sb;
          hi = p[31:0];
        end else begin
          up = ua / ub;
          lo = up[31:0];
          up = ua % ub;
          hi = up[31:0];
        end
      end
    endcase
  endfunction

  task automatic run_op(input string nm, input logic sel,
                        input logic [1:0] rop,
                        input logic [31:0] ra,
                        input logic [31:0] rb,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input logic ewr, input int elat);
    int lat;
    logic dn;
    op = rop;
    a = ra;
    b = rb;
    if (sel) f_start = 1'b1;
    else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    f_start = 1'b0;
    lat = 1;
    dn = sel ? f_done : s_done;
    while (!dn && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      dn = sel ? f_done : s_done;
    end
    check(nm, "done", {63'd0, dn}, 64'd1);
    check(nm, "lat", 64'(lat), 64'(elat));
    check(nm, "hi", {32'd0, sel ? f_hi : s_hi},
          {32'd0, ehi});
    check(nm, "lo", {32'd0, sel ? f_lo : s_lo},
          {32'd0, elo});
    check(nm, "whi", {63'd0, sel ? f_whi : s_whi},
          {63'd0, ewr});
    check(nm, "wlo", {63'd0, sel ? f_wlo : s_wlo},
          {63'd0, ewr});
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string nm);
    check(nm, "busy", {63'd0, s_busy}, 64'd0);
    check(nm, "done", {63'd0, s_done}, 64'd0);
    check(nm, "whi", {63'd0, s_whi}, 64'd0);
    check(nm, "wlo", {63'd0, s_wlo}, 64'd0);
    check(nm, "hi", {32'd0, s_hi}, 64'd0);
    check(nm, "lo", {32'd0, s_lo}, 64'd0);
  endtask

  initial begin
    logic [31:0] ehi, elo, phi, plo;
    logic        ewr;
    int          elat, nd;
    int          dcyc[2];
    logic [31:0] dhi[2];
    logic [31:0] dlo[2];

    tbl[0] = '{0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1, 34};
    tbl[1] = '{0, 2'b00, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1, 34};
    tbl[2] = '{1, 2'b00, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1, 3};
    tbl[3] = '{0, 2'b10, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1, 34};
    tbl[4] = '{0, 2'b11, 32'd7, 32'd2,
               32'd1, 32'd3, 1, 34};
    tbl[5] = '{0, 2'b10, 32'h80000000, 32'hFFFFFFFF,
               32'd0, 32'h80000000, 1, 34};
    tbl[6] = '{0, 2'b11, 32'h1234, 32'd0,
               32'h1234, 32'hFFFFFFFF, 0, 1};
    tbl[7] = '{1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1, 3};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].sel,
             tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi,
             tbl[i].lo, tbl[i].wr, tbl[i].lat);
    end

    for (int i = 0; i < 50; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      ref_model(rop, ra, rb, ehi, elo, ewr, elat);
      run_op($sformatf("rnd%0d", i), 1'b0, rop, ra, rb,
             ehi, elo, ewr, elat);
    end

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      ref_model(rop, ra, rb, ehi, elo, ewr, elat);
      run_op($sformatf("fast%0d", i), 1'b1, rop, ra, rb,
             ehi, elo, ewr, 3);
    end

    // Back-to-back with start held; changed inputs while busy
    op = 2'b01; a = 32'd5; b = 32'd6;
    start = 1'b1;
    @(posedge clk); #1;
    op = 2'b11; a = 32'd100; b = 32'd7;
    nd = 0;
    dcyc[0] = 0; dcyc[1] = 0;
    dhi[0] = '0; dhi[1] = '0;
    dlo[0] = '0; dlo[1] = '0;
    for (int c = 1; c <= 110; c++) begin
      if (s_done) begin
        if (nd < 2) begin
          dcyc[nd] = c;
          dhi[nd] = s_hi;
          dlo[nd] = s_lo;
        end
        nd++;
      end else if (nd >= 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("b2b", "pulses", 64'(nd), 64'd2);
    check("b2b", "cyc0", 64'(dcyc[0]), 64'd34);
    check("b2b", "cyc1", 64'(dcyc[1]), 64'd68);
    check("b2b", "lo0", {32'd0, dlo[0]}, 64'd30);
    check("b2b", "hi0", {32'd0, dhi[0]}, 64'd0);
    check("b2b", "lo1", {32'd0, dlo[1]}, 64'd14);
    check("b2b", "hi1", {32'd0, dhi[1]}, 64'd2);

    // Flush mid-calculation
    phi = s_hi;
    plo = s_lo;
    op = 2'b01; a = 32'd3; b = 32'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush", "busy", {63'd0, s_busy}, 64'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (s_done) nd++;
      @(posedge clk); #1;
    end
    check("flush", "pulses", 64'(nd), 64'd0);
    check("flush", "hi", {32'd0, s_hi}, {32'd0, phi});
    check("flush", "lo", {32'd0, s_lo}, {32'd0, plo});

    // Flush beats a simultaneous start
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start", "busy", {63'd0, s_busy}, 64'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (s_done) nd++;
      @(posedge clk); #1;
    end
    check("flush_start", "pulses", 64'(nd), 64'd0);

    // Reset mid-operation
    run_op("pre_rst", 1'b0, 2'b11, 32'd7, 32'd2,
           32'd1, 32'd3, 1'b1, 34);
    op = 2'b01; a = 32'hFFFF; b = 32'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_mid");
    rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (s_done) nd++;
      @(posedge clk); #1;
    end
    check("rst_mid", "pulses", 64'(nd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
